// File: rtl/axi_top.sv
// axi_top: register-mapped front end of the regex coprocessor.
// The host loads program code and the subject string into a shared
// 1024 x 40-bit memory, starts the regex engine on a byte range, and then
// reads back the accept/reject status and the elapsed cycle count.
//
// Engine program format (20-bit instruction, two per memory word):
//   [19:16] opcode, [11:8] operand B, [7:0] operand A
//   OP_CHAR  : consume one character equal to A
//   OP_ANY   : consume any one character
//   OP_SPLIT : fork to A[3:0] and B (no character consumed)
//   OP_JMP   : continue at A[3:0] (no character consumed)
//   OP_MATCH : accepting instruction
// Matching is anchored at both ends. The engine caches the first 16
// instructions (words 0..7), then runs a thread-set simulation: one bit per
// program counter, epsilon closure computed one expansion per cycle, and one
// character consumed per fetch/step pair.
//
// Engine handshake (valid/ready style): eng_start is a one-cycle request
// that the engine always accepts because the top only issues it while the
// engine is idle; eng_done is a one-cycle response that carries eng_accept
// as its payload; eng_abort returns the engine to idle at the next edge and
// suppresses any pending response.
module axi_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] data_in_register,
  input  logic [39:0] address_register,
  input  logic [39:0] start_cc_pointer_register,
  input  logic [39:0] end_cc_pointer_register,
  input  logic [39:0] cmd_register,
  output logic [39:0] status_register,
  output logic [39:0] data_o_register
);

  localparam int REG_WIDTH = 40;
  localparam int MEM_WORDS = 1024;
  localparam int AW        = 10;

  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 40'd1;
  localparam logic [REG_WIDTH-1:0] CMD_READ               = 40'd2;
  localparam logic [REG_WIDTH-1:0] CMD_START              = 40'd3;
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = 40'd4;
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 40'd5;

  localparam logic [1:0] STATUS_IDLE     = 2'd0;
  localparam logic [1:0] STATUS_RUNNING  = 2'd1;
  localparam logic [1:0] STATUS_ACCEPTED = 2'd2;
  localparam logic [1:0] STATUS_REJECTED = 2'd3;

  localparam logic [3:0] OP_CHAR  = 4'd0;
  localparam logic [3:0] OP_ANY   = 4'd1;
  localparam logic [3:0] OP_SPLIT = 4'd2;
  localparam logic [3:0] OP_JMP   = 4'd3;
  localparam logic [3:0] OP_MATCH = 4'd4;

  localparam logic [2:0] E_IDLE  = 3'd0;
  localparam logic [2:0] E_LOAD  = 3'd1;
  localparam logic [2:0] E_CLOSE = 3'd2;
  localparam logic [2:0] E_FETCH = 3'd3;
  localparam logic [2:0] E_STEP  = 3'd4;

  // ---------------------------------------------------------------------
  // Host side
  // ---------------------------------------------------------------------
  logic                 cmd_write, cmd_read, cmd_start, cmd_reset, cmd_elapsed;
  logic                 running, host_we, start_ok;
  logic [AW-1:0]        host_addr;
  logic                 unused_addr_bits;

  logic [1:0]           status_q, status_d;
  logic [REG_WIDTH-1:0] counter_q, counter_d;
  logic [REG_WIDTH-1:0] start_ptr_q, start_ptr_d;
  logic [REG_WIDTH-1:0] end_ptr_q, end_ptr_d;
  logic                 eng_start_q, eng_start_d;
  logic [REG_WIDTH-1:0] data_o_q;

  logic [REG_WIDTH-1:0] mem_q [0:MEM_WORDS-1];

  // Engine-side nets
  logic                 eng_start, eng_abort;
  logic [REG_WIDTH-1:0] eng_start_ptr, eng_end_ptr;
  logic [AW-1:0]        eng_mem_addr;
  logic [REG_WIDTH-1:0] eng_mem_data;
  logic                 eng_done, eng_accept;

  // Addresses wrap modulo the memory depth; the upper bits are don't-care.
  assign host_addr        = address_register[AW-1:0];
  assign unused_addr_bits = ^address_register[REG_WIDTH-1:AW];

  // Decode the level-sensitive command; NOP and undefined codes set no flag.
  always_comb begin
    cmd_write   = 1'b0;
    cmd_read    = 1'b0;
    cmd_start   = 1'b0;
    cmd_reset   = 1'b0;
    cmd_elapsed = 1'b0;
    case (cmd_register)
      CMD_WRITE:              cmd_write   = 1'b1;
      CMD_READ:               cmd_read    = 1'b1;
      CMD_START:              cmd_start   = 1'b1;
      CMD_RESET:              cmd_reset   = 1'b1;
      CMD_READ_ELAPSED_CLOCK: cmd_elapsed = 1'b1;
      default: ;
    endcase
  end

  assign running  = (status_q == STATUS_RUNNING);
  assign host_we  = cmd_write && !running;
  assign start_ok = cmd_start && !running;

  // Status / counter next state: RESET wins over START and over a
  // completing engine; a finished run freezes the counter.
  always_comb begin
    status_d    = status_q;
    counter_d   = counter_q;
    start_ptr_d = start_ptr_q;
    end_ptr_d   = end_ptr_q;
    eng_start_d = 1'b0;
    if (cmd_reset) begin
      status_d  = STATUS_IDLE;
      counter_d = '0;
    end else if (start_ok) begin
      status_d    = STATUS_RUNNING;
      counter_d   = '0;
      start_ptr_d = start_cc_pointer_register;
      end_ptr_d   = end_cc_pointer_register;
      eng_start_d = 1'b1;
    end else if (running) begin
      if (counter_q != {REG_WIDTH{1'b1}}) counter_d = counter_q + 40'd1;
      if (eng_done) status_d = eng_accept ? STATUS_ACCEPTED : STATUS_REJECTED;
    end
  end

  // Control registers of the host side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q    <= STATUS_IDLE;
      counter_q   <= '0;
      start_ptr_q <= '0;
      end_ptr_q   <= '0;
      eng_start_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      counter_q   <= counter_d;
      start_ptr_q <= start_ptr_d;
      end_ptr_q   <= end_ptr_d;
      eng_start_q <= eng_start_d;
    end
  end

  // Read-data register: memory word on READ (when idle), counter on
  // READ_ELAPSED_CLOCK; otherwise it holds, including across CMD_RESET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o_q <= '0;
    end else if (cmd_read && !running) begin
      data_o_q <= mem_q[host_addr];
    end else if (cmd_elapsed) begin
      data_o_q <= counter_q;
    end
  end

  // Host write port; the memory is never cleared.
  always_ff @(posedge clk) begin
    if (host_we) mem_q[host_addr] <= data_in_register;
  end

  // Engine read port, one cycle of latency.
  always_ff @(posedge clk) begin
    eng_mem_data <= mem_q[eng_mem_addr];
  end

  assign status_register = {{(REG_WIDTH-2){1'b0}}, status_q};
  assign data_o_register = data_o_q;

  assign eng_start     = eng_start_q;
  assign eng_abort     = cmd_reset;
  assign eng_start_ptr = start_ptr_q;
  assign eng_end_ptr   = end_ptr_q;

  // ---------------------------------------------------------------------
  // Regex engine
  // ---------------------------------------------------------------------
  logic [2:0]           e_state_q, e_state_d;
  logic [3:0]           load_cnt_q, load_cnt_d;
  logic [15:0]          set_q, set_d;
  logic [REG_WIDTH-1:0] ptr_q, ptr_d;
  logic [REG_WIDTH-1:0] end_q, end_d;
  logic [AW-1:0]        word_q, word_d;
  logic [2:0]           off_q, off_d;
  logic                 done_q, done_d;
  logic                 accept_q, accept_d;

  logic [15:0]          instr_q [0:15];
  logic [15:0]          close_set, step_set;
  logic                 set_has_match;
  logic [7:0]           cur_char;
  logic [2:0]           load_idx;

  // Only the low 13 pointer bits address the 5120 bytes of memory.
  logic [12:0]          start_byte, start_word_full, start_off_full;
  logic                 unused_div_bits;

  assign start_byte      = eng_start_ptr[12:0];
  assign start_word_full = start_byte / 13'd5;
  assign start_off_full  = start_byte % 13'd5;
  assign unused_div_bits = ^{start_word_full[12:AW], start_off_full[12:3]};
  assign load_idx        = load_cnt_q[2:0] - 3'd1;

  // Pick the current character out of the fetched word.
  always_comb begin
    case (off_q)
      3'd0:    cur_char = eng_mem_data[7:0];
      3'd1:    cur_char = eng_mem_data[15:8];
      3'd2:    cur_char = eng_mem_data[23:16];
      3'd3:    cur_char = eng_mem_data[31:24];
      default: cur_char = eng_mem_data[39:32];
    endcase
  end

  // One epsilon-expansion of the thread set, the character step, and the
  // presence of an accepting thread, all from the current thread set.
  always_comb begin
    close_set     = set_q;
    step_set      = '0;
    set_has_match = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (set_q[i]) begin
        case (instr_q[i][15:12])
          OP_JMP:   close_set[instr_q[i][3:0]] = 1'b1;
          OP_SPLIT: begin
            close_set[instr_q[i][3:0]]  = 1'b1;
            close_set[instr_q[i][11:8]] = 1'b1;
          end
          OP_MATCH: set_has_match = 1'b1;
          OP_ANY:   step_set[4'(i + 1)] = 1'b1;
          OP_CHAR:  if (instr_q[i][7:0] == cur_char) step_set[4'(i + 1)] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Engine sequencing: load program cache, then alternate closure and
  // fetch/step until the string is consumed or no thread survives.
  always_comb begin
    e_state_d    = e_state_q;
    load_cnt_d   = load_cnt_q;
    set_d        = set_q;
    ptr_d        = ptr_q;
    end_d        = end_q;
    word_d       = word_q;
    off_d        = off_q;
    done_d       = 1'b0;
    accept_d     = accept_q;
    eng_mem_addr = word_q;
    case (e_state_q)
      E_IDLE: begin
        if (eng_start) begin
          e_state_d  = E_LOAD;
          load_cnt_d = '0;
          ptr_d      = eng_start_ptr;
          end_d      = eng_end_ptr;
          word_d     = start_word_full[AW-1:0];
          off_d      = start_off_full[2:0];
        end
      end
      E_LOAD: begin
        eng_mem_addr = AW'(load_cnt_q[2:0]);
        load_cnt_d   = load_cnt_q + 4'd1;
        if (load_cnt_q == 4'd8) begin
          e_state_d = E_CLOSE;
          set_d     = 16'h0001;
        end
      end
      E_CLOSE: begin
        if (close_set != set_q) begin
          set_d = close_set;
        end else if (set_q == '0 || ptr_q > end_q) begin
          done_d    = 1'b1;
          accept_d  = set_has_match && (set_q != '0) && (ptr_q > end_q);
          e_state_d = E_IDLE;
        end else begin
          e_state_d = E_FETCH;
        end
      end
      E_FETCH: begin
        eng_mem_addr = word_q;
        e_state_d    = E_STEP;
      end
      E_STEP: begin
        set_d = step_set;
        ptr_d = ptr_q + 40'd1;
        if (off_q == 3'd4) begin
          off_d  = 3'd0;
          word_d = word_q + 10'd1;
        end else begin
          off_d = off_q + 3'd1;
        end
        e_state_d = E_CLOSE;
      end
      default: e_state_d = E_IDLE;
    endcase
    if (eng_abort) begin
      e_state_d = E_IDLE;
      done_d    = 1'b0;
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_state_q  <= E_IDLE;
      load_cnt_q <= '0;
      set_q      <= '0;
      ptr_q      <= '0;
      end_q      <= '0;
      word_q     <= '0;
      off_q      <= '0;
      done_q     <= 1'b0;
      accept_q   <= 1'b0;
    end else begin
      e_state_q  <= e_state_d;
      load_cnt_q <= load_cnt_d;
      set_q      <= set_d;
      ptr_q      <= ptr_d;
      end_q      <= end_d;
      word_q     <= word_d;
      off_q      <= off_d;
      done_q     <= done_d;
      accept_q   <= accept_d;
    end
  end

  // Program cache fill: word k-1 arrives while load_cnt is k.
  always_ff @(posedge clk) begin
    if (e_state_q == E_LOAD && load_cnt_q != 4'd0) begin
      instr_q[{load_idx, 1'b0}] <= {eng_mem_data[19:16], eng_mem_data[11:8], eng_mem_data[7:0]};
      instr_q[{load_idx, 1'b1}] <= {eng_mem_data[39:36], eng_mem_data[31:28], eng_mem_data[27:20]};
    end
  end

  assign eng_done   = done_q;
  assign eng_accept = accept_q;

endmodule

// File: tb/tb_axi_top.sv
// tb_axi_top: randomized self-checking bench for axi_top. Expected memory
// contents come from a bench-side image; expected match results come from
// the regular-expression rules evaluated directly on the string.
module tb_axi_top;

  localparam logic [39:0] CMD_NOP     = 40'd0;
  localparam logic [39:0] CMD_WRITE   = 40'd1;
  localparam logic [39:0] CMD_READ    = 40'd2;
  localparam logic [39:0] CMD_START   = 40'd3;
  localparam logic [39:0] CMD_RESET   = 40'd4;
  localparam logic [39:0] CMD_ELAPSED = 40'd5;

  localparam logic [39:0] ST_IDLE = 40'd0;
  localparam logic [39:0] ST_RUN  = 40'd1;
  localparam logic [39:0] ST_ACC  = 40'd2;
  localparam logic [39:0] ST_REJ  = 40'd3;

  localparam logic [3:0] OP_CHAR = 4'd0, OP_ANY = 4'd1, OP_SPLIT = 4'd2,
                         OP_JMP = 4'd3, OP_MATCH = 4'd4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] data_in, addr, sp, ep, cmd;
  logic [39:0] status, data_o;

  always #5 clk = ~clk;

  axi_top dut (
    .clk                       (clk),
    .rst                       (rst),
    .data_in_register          (data_in),
    .address_register          (addr),
    .start_cc_pointer_register (sp),
    .end_cc_pointer_register   (ep),
    .cmd_register              (cmd),
    .status_register           (status),
    .data_o_register           (data_o)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [39:0] exp_mem [0:1023];
  logic [39:0] exp_q[$];
  logic [39:0] last_dout_exp;
  logic [7:0]  str_q[$];
  logic [19:0] prog_q[$];

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [39:0] d);
    cmd = CMD_WRITE; addr = 40'(a); data_in = d;
    tick();
    cmd = CMD_NOP;
    exp_mem[a % 1024] = d;
  endtask

  task automatic host_read(input int a, output logic [39:0] v);
    cmd = CMD_READ; addr = 40'(a);
    tick();
    v = data_o;
    cmd = CMD_NOP;
  endtask

  task automatic check_mem(input string tag, input int a);
    logic [39:0] v;
    host_read(a, v);
    check_eq(tag, v, exp_mem[a % 1024]);
    last_dout_exp = exp_mem[a % 1024];
  endtask

  task automatic read_elapsed(output logic [39:0] v);
    cmd = CMD_ELAPSED;
    tick();
    v = data_o;
    cmd = CMD_NOP;
  endtask

  function automatic logic [19:0] ins(input logic [3:0] op, input logic [7:0] a, input logic [3:0] b);
    return {op, 4'h0, b, a};
  endfunction

  task automatic load_prog();
    logic [19:0] lo, hi;
    for (int w = 0; w < (prog_q.size() + 1) / 2; w++) begin
      lo = prog_q[2*w];
      hi = (2*w + 1 < prog_q.size()) ? prog_q[2*w + 1] : 20'h0;
      host_write(w, {hi, lo});
    end
  endtask

  // Places str_q at byte address base; bytes around it keep their image.
  task automatic load_string(input int base);
    logic [39:0] word;
    int b;
    if (str_q.size() == 0) return;
    for (int i = 0; i < str_q.size(); i++) begin
      b = base + i;
      word = exp_mem[b / 5];
      word[8*(b % 5) +: 8] = str_q[i];
      exp_mem[b / 5] = word;
    end
    for (int w = base / 5; w <= (base + str_q.size() - 1) / 5; w++)
      host_write(w, exp_mem[w]);
  endtask

  // Reference rules for the two programs.
  function automatic bit model_abc();
    if (str_q.size() == 0 || str_q[0] != 8'h61) return 1'b0;
    for (int i = 1; i < str_q.size(); i++)
      if (str_q[i] != 8'h62 && str_q[i] != 8'h63) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_a_any_c();
    return str_q.size() == 3 && str_q[0] == 8'h61 && str_q[2] == 8'h63;
  endfunction

  task automatic gen_abc_str(input int len);
    str_q.delete();
    for (int i = 0; i < len; i++) begin
      if (i == 0 && $urandom_range(0, 3) != 0) str_q.push_back(8'h61);
      else if (i > 0 && $urandom_range(0, 4) != 0) str_q.push_back(8'(8'h62 + $urandom_range(0, 1)));
      else str_q.push_back(8'(8'h61 + $urandom_range(0, 3)));
    end
  endtask

  // Starts a run over str_q at base, measures edges until completion and
  // checks status and elapsed count. With disturb set, a WRITE to word 0
  // and a second START are issued while the run is in progress.
  task automatic run_regex(input string tag, input int base, input bit exp_acc, input bit disturb);
    int          edges;
    bit          running_seen, done;
    logic [39:0] v;
    sp  = 40'(base);
    ep  = 40'(base + str_q.size()) - 40'd1;
    cmd = CMD_START;
    tick();
    edges = 0;
    cmd = CMD_NOP;
    running_seen = (status == ST_RUN);
    done = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      if (disturb && edges == 3) begin
        cmd = CMD_WRITE; addr = 40'd0; data_in = '1;
      end else if (disturb && edges == 5) begin
        cmd = CMD_START;
      end else begin
        cmd = CMD_NOP;
      end
      tick();
      edges++;
      if (edges <= 2 && status == ST_RUN) running_seen = 1'b1;
      if (running_seen && status != ST_RUN) done = 1'b1;
    end
    cmd = CMD_NOP;
    check_eq($sformatf("%s_running", tag), {39'b0, running_seen}, 40'd1);
    check_eq($sformatf("%s_done", tag), {39'b0, done}, 40'd1);
    check_eq($sformatf("%s_status", tag), status, exp_acc ? ST_ACC : ST_REJ);
    read_elapsed(v);
    check_eq($sformatf("%s_elapsed", tag), v, 40'(edges));
    last_dout_exp = 40'(edges);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [39:0] v;
    int          base;
    rst = 1'b1; cmd = CMD_NOP; addr = '0; data_in = '0; sp = '0; ep = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    repeat (3) tick();
    check_eq("reset_status", status, ST_IDLE);
    check_eq("reset_dout", data_o, 40'd0);
    rst = 1'b0;
    tick();
    check_eq("post_reset_status", status, ST_IDLE);

    // single write/read
    host_write(5, 40'h12345_6789A);
    check_mem("rw_word5", 5);

    // address wrap
    host_write(1024 + 7, 40'hCAFE0_0BEEF);
    check_mem("wrap_read7", 7);
    check_mem("wrap_read2055", 2048 + 7);

    // streamed writes with WRITE held
    for (int i = 0; i < 4; i++) begin
      cmd = CMD_WRITE; addr = 40'(i); data_in = 40'(10 + i);
      tick();
      exp_mem[i] = 40'(10 + i);
      exp_q.push_back(40'(10 + i));
    end
    cmd = CMD_NOP;
    for (int i = 0; i < 4; i++) begin
      host_read(i, v);
      check_eq($sformatf("stream_w%0d", i), v, exp_q.pop_front());
    end

    // program a(b|c)*
    prog_q = '{ins(OP_CHAR, 8'h61, 4'd0), ins(OP_SPLIT, 8'd2, 4'd7),
               ins(OP_SPLIT, 8'd3, 4'd5), ins(OP_CHAR, 8'h62, 4'd0),
               ins(OP_JMP, 8'd1, 4'd0),   ins(OP_CHAR, 8'h63, 4'd0),
               ins(OP_JMP, 8'd1, 4'd0),   ins(OP_MATCH, 8'd0, 4'd0)};
    load_prog();

    str_q = '{8'h61, 8'h62, 8'h63, 8'h62};
    load_string(53);
    run_regex("abcb", 53, model_abc(), 1'b0);
    read_elapsed(v);
    check_eq("abcb_elapsed_nonzero", {39'b0, (v != 40'd0)}, 40'd1);
    last_dout_exp = v;

    cmd = CMD_RESET; tick(); cmd = CMD_NOP;
    check_eq("cmdreset_status", status, ST_IDLE);
    read_elapsed(v);
    check_eq("cmdreset_counter", v, 40'd0);
    last_dout_exp = 40'd0;

    str_q = '{8'h61, 8'h62, 8'h64};
    load_string(53);
    run_regex("abd", 53, model_abc(), 1'b0);

    // host commands ignored while running
    str_q.delete();
    str_q.push_back(8'h61);
    for (int i = 0; i < 30; i++) str_q.push_back(8'(8'h62 + $urandom_range(0, 1)));
    load_string(100);
    run_regex("disturb", 100, model_abc(), 1'b1);
    check_mem("disturb_word0", 0);

    // CMD_RESET mid-run
    sp = 40'd100; ep = 40'd130;
    cmd = CMD_START; tick(); cmd = CMD_NOP;
    repeat (10) tick();
    check_eq("midrun_running", status, ST_RUN);
    cmd = CMD_RESET; tick(); cmd = CMD_NOP;
    check_eq("midrun_status", status, ST_IDLE);
    check_eq("midrun_dout", data_o, last_dout_exp);
    read_elapsed(v);
    check_eq("midrun_counter", v, 40'd0);
    repeat (100) tick();
    check_eq("midrun_stays_idle", status, ST_IDLE);
    for (int i = 0; i < 4; i++) check_mem($sformatf("midrun_mem%0d", i), i);

    // RESET immediately followed by a fresh run
    cmd = CMD_START; tick();
    repeat (4) tick();
    cmd = CMD_RESET; tick(); cmd = CMD_NOP;
    str_q = '{8'h61, 8'h63};
    load_string(300);
    run_regex("restart", 300, model_abc(), 1'b0);

    // randomized strings, a(b|c)*
    for (int t = 0; t < 10; t++) begin
      gen_abc_str($urandom_range(0, 8));
      base = $urandom_range(40, 4000);
      load_string(base);
      run_regex($sformatf("rnd_abc%0d", t), base, model_abc(), 1'b0);
    end

    // program a.c
    prog_q = '{ins(OP_CHAR, 8'h61, 4'd0), ins(OP_ANY, 8'd0, 4'd0),
               ins(OP_CHAR, 8'h63, 4'd0), ins(OP_MATCH, 8'd0, 4'd0)};
    load_prog();
    for (int t = 0; t < 8; t++) begin
      str_q.delete();
      for (int i = 0; i < $urandom_range(2, 4); i++) begin
        if (i == 0 && $urandom_range(0, 3) != 0) str_q.push_back(8'h61);
        else if (i == 2 && $urandom_range(0, 3) != 0) str_q.push_back(8'h63);
        else str_q.push_back(8'(8'h61 + $urandom_range(0, 25)));
      end
      base = $urandom_range(40, 4000);
      load_string(base);
      run_regex($sformatf("rnd_anyc%0d", t), base, model_a_any_c(), 1'b0);
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
